// File: rtl/fec_pkg.sv
// Shared types and constants for the frame serializer.
// Holds the FSM state type and the frame format word counts.
package fec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } ser_state_e;

  localparam int FMT0_WORDS       = 8;
  localparam int FMT1_WORDS       = 4;
  localparam int DEF_CLKS_PER_BIT = 16;

endpackage

// File: rtl/frame_serializer_bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT cycles per line bit.
// tick marks the last cycle of each period; restart holds it at zero.
module bit_timer
  import fec_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CNT_LAST) & ~restart;

  // Next count: wrap to zero at the end of a period or on restart
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart || tick) begin
      cnt_d = '0;
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/frame_serializer.sv
// Frame serializer: sends N words as start/data(LSB first)/stop bits.
// N is 4 for the short format, DATA_DEPTH otherwise; tx_out is registered.
module frame_serializer
  import fec_pkg::*;
#(
  parameter int DATA_WIDTH   = 10,
  parameter int DATA_DEPTH   = FMT0_WORDS,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] par_in,
  input  logic                                 enc_used,
  input  logic                                 load_valid,
  output logic                                 load_ready,
  output logic                                 tx_out,
  output logic                                 busy,
  output logic                                 frame_done
);

  localparam int WI_W = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam int BI_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [WI_W-1:0] LAST_W0 = WI_W'(DATA_DEPTH - 1);
  localparam logic [WI_W-1:0] LAST_W1 = WI_W'(FMT1_WORDS - 1);
  localparam logic [BI_W-1:0] LAST_B  = BI_W'(DATA_WIDTH - 1);

  ser_state_e state_q, state_d;

  logic [WI_W-1:0] word_q, word_d;
  logic [BI_W-1:0] bit_q, bit_d;
  logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] buf_q, buf_d;
  logic enc_q, enc_d;
  logic tx_q, tx_d;
  logic tick, restart, accept, last_word, last_bit;

  assign restart   = (state_q == ST_IDLE);
  assign accept    = load_valid & (state_q == ST_IDLE);
  assign last_word = enc_q ? (word_q == LAST_W1) : (word_q == LAST_W0);
  assign last_bit  = (bit_q == LAST_B);
  assign tx_out    = tx_q;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .tick   (tick)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: advance on bit-period ticks
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_START;
      ST_START: if (tick) state_d = ST_DATA;
      ST_DATA:  if (tick && last_bit) state_d = ST_STOP;
      ST_STOP:  if (tick) state_d = last_word ? ST_IDLE : ST_START;
    endcase
  end

  // Datapath next values; tx_d looks ahead so the line moves with state
  always_comb begin
    word_d = word_q;
    bit_d  = bit_q;
    buf_d  = buf_q;
    enc_d  = enc_q;
    if (accept) begin
      buf_d  = par_in;
      enc_d  = enc_used;
      word_d = '0;
      bit_d  = '0;
    end
    if (tick) begin
      unique case (state_q)
        ST_DATA: bit_d = last_bit ? '0 : bit_q + BI_W'(1);
        ST_STOP: begin
          word_d = last_word ? '0 : word_q + WI_W'(1);
          bit_d  = '0;
        end
        default: bit_d = '0;
      endcase
    end
    unique case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = buf_q[word_d][bit_d];
      default:  tx_d = 1'b1;
    endcase
  end

  // Datapath registers; line idles high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      bit_q  <= '0;
      buf_q  <= '0;
      enc_q  <= 1'b0;
      tx_q   <= 1'b1;
    end else begin
      word_q <= word_d;
      bit_q  <= bit_d;
      buf_q  <= buf_d;
      enc_q  <= enc_d;
      tx_q   <= tx_d;
    end
  end

  // Status outputs decoded from the current state
  always_comb begin
    load_ready = (state_q == ST_IDLE);
    busy       = (state_q != ST_IDLE);
    frame_done = (state_q == ST_STOP) & tick & last_word;
  end

endmodule

// File: tb/tb_frame_serializer.sv
// Testbench for frame_serializer: bit-stream model plus decoded-word checks.
// Inputs change on falling edges; outputs are checked 1 time unit after rising edges.
module tb_frame_serializer;

  localparam int W  = 10;
  localparam int D  = 8;
  localparam int C  = 16;
  localparam int WB = (W + 2) * C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [D-1:0][W-1:0] par_in = '0;
  logic enc_used = 1'b0;
  logic load_valid = 1'b0;
  logic load_ready, tx_out, busy, frame_done;

  frame_serializer #(
    .DATA_WIDTH  (W),
    .DATA_DEPTH  (D),
    .CLKS_PER_BIT(C)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .par_in    (par_in),
    .enc_used  (enc_used),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .tx_out    (tx_out),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit mq[$];
  bit m_busy = 1'b0;
  bit m_tx = 1'b1;
  bit m_done = 1'b0;
  int m_len = 0;

  bit cap[$];
  bit last[$];
  int done_cnt = 0;
  int idle_run = 0;
  int gap = -1;
  bit prev_busy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected line waveform of a whole frame, one entry per clock
  function automatic void push_frame(input logic [D-1:0][W-1:0] p,
                                     input logic e);
    int n;
    n = e ? 4 : D;
    m_len = n * WB;
    for (int k = 0; k < n; k++) begin
      repeat (C) mq.push_back(1'b0);
      for (int b = 0; b < W; b++) begin
        repeat (C) mq.push_back(p[k][b]);
      end
      repeat (C) mq.push_back(1'b1);
    end
  endfunction

  // Recover word k from the last captured frame by mid-bit sampling
  function automatic logic [W-1:0] dec(input int k);
    logic [W-1:0] v;
    v = '0;
    for (int b = 0; b < W; b++) begin
      v[b] = last[k * WB + (b + 1) * C + C / 2];
    end
    return v;
  endfunction

  // Model update at each rising edge, compare shortly after
  always @(posedge clk) begin : mdl
    logic r, lv, e;
    logic [D-1:0][W-1:0] p;
    r = rst;
    lv = load_valid;
    e = enc_used;
    p = par_in;
    if (r) begin
      mq.delete();
      cap.delete();
      m_busy = 1'b0;
    end else if (!m_busy && lv) begin
      push_frame(p, e);
    end
    if (!r && mq.size() > 0) begin
      m_tx = mq.pop_front();
      m_busy = 1'b1;
      m_done = (mq.size() == 0);
    end else begin
      m_tx = 1'b1;
      m_busy = 1'b0;
      m_done = 1'b0;
    end
    #1;
    chk("tx_out", 32'(tx_out), 32'(m_tx));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("load_ready", 32'(load_ready), 32'(!m_busy));
    chk("frame_done", 32'(frame_done), 32'(m_done));
    if (busy === 1'b1) begin
      if (!prev_busy) gap = idle_run;
      idle_run = 0;
      cap.push_back(tx_out);
    end else begin
      idle_run++;
    end
    prev_busy = (busy === 1'b1);
    if (frame_done === 1'b1) begin
      last = cap;
      cap.delete();
      done_cnt++;
    end
  end

  task automatic wait_done(input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_count", 32'(done_cnt), 32'(target));
  endtask

  task automatic send(input logic [D-1:0][W-1:0] p, input logic e);
    @(negedge clk);
    par_in = p;
    enc_used = e;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  logic [D-1:0][W-1:0] pa, pb, pc;
  logic [W-1:0] f1[4];

  initial begin
    f1[0] = 10'h3FF;
    f1[1] = 10'h000;
    f1[2] = 10'h155;
    f1[3] = 10'h2AA;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_tx", 32'(tx_out), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(load_ready), 32'd1);

    // Format 0, word k = 0x200|k
    for (int k = 0; k < D; k++) pa[k] = W'(10'h200 | k);
    send(pa, 1'b0);
    wait_done(1, 1700);
    chk("f0_len", 32'(last.size()), 32'd1536);
    chk("f0_model_len", 32'(m_len), 32'd1536);
    for (int k = 0; k < D; k++) chk("f0_word", 32'(dec(k)), 32'(10'h200 | k));

    // Format 1, upper words must never appear on the line
    for (int k = 0; k < D; k++) pb[k] = (k < 4) ? f1[k] : W'(10'h0F0);
    send(pb, 1'b1);
    wait_done(2, 900);
    chk("f1_len", 32'(last.size()), 32'd768);
    chk("f1_model_len", 32'(m_len), 32'd768);
    for (int k = 0; k < 4; k++) chk("f1_word", 32'(dec(k)), 32'(f1[k]));

    // par_in overwritten shortly after acceptance
    for (int k = 0; k < D; k++) pc[k] = W'(10'h0A5 ^ (k * 37));
    send(pc, 1'b0);
    repeat (4) @(negedge clk);
    par_in = '1;
    wait_done(3, 1700);
    for (int k = 0; k < D; k++) chk("hold_word", 32'(dec(k)), 32'(pc[k]));

    // Back-to-back with load_valid held high through frame A
    for (int k = 0; k < D; k++) pa[k] = W'(10'h100 + k * 3);
    for (int k = 0; k < D; k++) pb[k] = W'(10'h3C0 ^ k);
    @(negedge clk);
    par_in = pa;
    enc_used = 1'b0;
    load_valid = 1'b1;
    repeat (10) @(negedge clk);
    chk("busy_ready", 32'(load_ready), 32'd0);
    par_in = pb;
    wait_done(4, 1700);
    gap = -1;
    for (int k = 0; k < D; k++) chk("b2b_a_word", 32'(dec(k)), 32'(pa[k]));
    repeat (3) @(negedge clk);
    load_valid = 1'b0;
    chk("b2b_gap", 32'(gap), 32'd1);
    wait_done(5, 1700);
    for (int k = 0; k < D; k++) chk("b2b_b_word", 32'(dec(k)), 32'(pb[k]));

    // Reset during word 3 data bits, load_valid asserted under reset
    for (int k = 0; k < D; k++) pa[k] = W'(k * 5 + 1);
    send(pa, 1'b0);
    repeat (640) @(negedge clk);
    rst = 1'b1;
    load_valid = 1'b1;
    #1;
    chk("abort_tx", 32'(tx_out), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    load_valid = 1'b0;
    for (int k = 0; k < D; k++) pc[k] = (k < 4) ? f1[3 - k] : W'(10'h1E1);
    send(pc, 1'b1);
    wait_done(6, 900);
    chk("post_rst_len", 32'(last.size()), 32'd768);
    for (int k = 0; k < 4; k++) chk("post_rst_word", 32'(dec(k)), 32'(f1[3 - k]));

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
